// File: rtl/kiwi_run_monitor_pkg.sv
// Shared types and helpers for the Kiwi run monitor.
package kiwi_mon_pkg;

  typedef enum logic [1:0] {
    RUN,
    FINISHED,
    TIMEDOUT
  } mon_state_t;

  // Channel index width; a single thread still needs one bit.
  function automatic int unsigned chan_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kiwi_run_monitor_if.sv
// Event readout handshake between the run monitor and its consumer.
interface kiwi_run_monitor_if #(
  parameter int unsigned CW    = 1,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned WP_W  = 640
);
  logic             ev_valid;
  logic             ev_ready;
  logic [CW-1:0]    ev_chan;
  logic [CNT_W-1:0] ev_cycle;
  logic [CNT_W-1:0] ev_delta;
  logic [WP_W-1:0]  ev_waypoint;

  modport master (
    output ev_valid, ev_chan, ev_cycle, ev_delta, ev_waypoint,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_chan, ev_cycle, ev_delta, ev_waypoint,
    output ev_ready
  );
endinterface

// File: rtl/kiwi_ev_fifo.sv
// First-word fall-through FIFO; pointers carry an extra wrap bit for full/empty.
module kiwi_ev_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rdata   = mem[rd_ptr[AW-1:0]];
  assign do_push = push && !full;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push)       wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/kiwi_run_monitor.sv
// Multi-thread run monitor: cycle counter, finish/watchdog FSM, waypoint event capture.
module kiwi_run_monitor
  import kiwi_mon_pkg::*;
#(
  parameter int unsigned NCH        = 2,
  parameter int unsigned WP_W       = 640,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned TIMEOUT    = 0,
  parameter int unsigned EV_DEPTH   = 16,
  parameter int unsigned FINISH_ANY = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NCH-1:0]      done_i,
  input  logic [NCH*WP_W-1:0] waypoint_i,
  kiwi_run_monitor_if.master  ev,
  output logic [CNT_W-1:0]    cycles,
  output logic [NCH-1:0]      chan_done,
  output logic                finish,
  output logic                timed_out,
  output logic [CNT_W-1:0]    ev_dropped
);
  localparam int unsigned      CW      = chan_w(NCH);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  typedef struct packed {
    logic [CW-1:0]    chan;
    logic [CNT_W-1:0] cycle;
    logic [CNT_W-1:0] delta;
    logic [WP_W-1:0]  waypoint;
  } ev_t;

  mon_state_t       state, state_nx;
  logic [NCH-1:0]   done_nx;
  logic             fin_cond;
  logic             run;

  logic [WP_W-1:0]  wp       [NCH];
  logic [WP_W-1:0]  last_wp  [NCH];
  logic [CNT_W-1:0] last_cyc [NCH];
  ev_t              new_ev   [NCH];
  ev_t              pend     [NCH];
  logic [NCH-1:0]   seen, hit, pend_vld, gnt, drop;
  ev_t              push_ev, head_ev;
  logic             push, pop, full, empty, found;
  logic [CNT_W:0]   drop_sum;

  assign run       = (state == RUN);
  assign finish    = (state == FINISHED);
  assign timed_out = (state == TIMEDOUT);

  // Finish looks at next-state chan_done so it is visible after the sampling edge.
  always_comb begin
    done_nx  = chan_done | done_i;
    fin_cond = (FINISH_ANY != 0) ? (|done_nx) : (&done_nx);
    state_nx = state;
    case (state)
      RUN: begin
        if (fin_cond)                                    state_nx = FINISHED;
        else if ((TIMEOUT != 0) && (cycles == TO_LAST))  state_nx = TIMEDOUT;
      end
      default: state_nx = state;
    endcase
  end

  always_comb begin
    for (int unsigned n = 0; n < NCH; n++) begin
      wp[n]     = waypoint_i[n*WP_W +: WP_W];
      hit[n]    = run && (seen[n] ? (wp[n] != last_wp[n]) : (wp[n] != '0));
      new_ev[n] = '{chan: CW'(n), cycle: cycles, delta: cycles - last_cyc[n], waypoint: wp[n]};
    end
  end

  // Fixed priority, lowest thread index wins; nothing is granted while the FIFO is full.
  always_comb begin
    gnt     = '0;
    push_ev = pend[0];
    found   = 1'b0;
    for (int unsigned n = 0; n < NCH; n++) begin
      if (!found && !full && pend_vld[n]) begin
        gnt[n]  = 1'b1;
        push_ev = pend[n];
        found   = 1'b1;
      end
    end
    push = found;
  end

  assign drop = hit & pend_vld & ~gnt;

  always_comb begin
    drop_sum = {1'b0, ev_dropped};
    for (int unsigned n = 0; n < NCH; n++) begin
      drop_sum = drop_sum + (CNT_W+1)'(drop[n]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RUN;
      cycles     <= '0;
      chan_done  <= '0;
      ev_dropped <= '0;
      seen       <= '0;
      pend_vld   <= '0;
      for (int unsigned n = 0; n < NCH; n++) begin
        last_wp[n]  <= '0;
        last_cyc[n] <= '0;
        pend[n]     <= '0;
      end
    end else begin
      state <= state_nx;
      if (run) begin
        chan_done <= done_nx;
        if (cycles != '1) cycles <= cycles + CNT_W'(1);
      end
      ev_dropped <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      for (int unsigned n = 0; n < NCH; n++) begin
        if (hit[n]) begin
          last_wp[n]  <= wp[n];
          last_cyc[n] <= cycles;
          seen[n]     <= 1'b1;
          pend[n]     <= new_ev[n];
          pend_vld[n] <= 1'b1;
        end else if (gnt[n]) begin
          pend_vld[n] <= 1'b0;
        end
      end
    end
  end

  kiwi_ev_fifo #(
    .WIDTH ($bits(ev_t)),
    .DEPTH (EV_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (push_ev),
    .full  (full),
    .pop   (pop),
    .rdata (head_ev),
    .empty (empty)
  );

  assign pop            = !empty && ev.ev_ready;
  assign ev.ev_valid    = !empty;
  assign ev.ev_chan     = head_ev.chan;
  assign ev.ev_cycle    = head_ev.cycle;
  assign ev.ev_delta    = head_ev.delta;
  assign ev.ev_waypoint = head_ev.waypoint;
endmodule
